rptr_empty_level: RTL and testbench
===================================

RPTR_EMPTY_LEVEL -- requirements
Module: rptr_empty_level

Interface
REQ-001 The block SHALL have parameter ADDRSIZE, default 4, meaning FIFO depth = 2**ADDRSIZE entries (ADDRSIZE >= 2).
REQ-002 The block SHALL have parameter AE_RESET, default 2, meaning reset value of the internal almost-empty threshold register.
REQ-003 Port rclk  input  1  read-domain clock, all state rising-edge.
REQ-004 Port rrst  input  1  synchronous active-high reset.
REQ-005 Port rinc  input  1  read request; honoured only when rempty=0.
REQ-006 Port rq2_wptr  input  ADDRSIZE+1  write pointer, Gray, already synchronised into rclk domain.
REQ-007 Port ae_load  input  1  load strobe for almost-empty threshold.
REQ-008 Port ae_thresh  input  ADDRSIZE+1  threshold value captured when ae_load=1.
REQ-009 Port raddr  output  ADDRSIZE  binary read address to RAM (rbin low bits).
REQ-010 Port rptr  output  ADDRSIZE+1  registered Gray read pointer, for sync to write domain.
REQ-011 Port rempty  output  1  FIFO empty, registered.
REQ-012 Port raempty  output  1  occupancy <= threshold, registered.
REQ-013 Port rlevel  output  ADDRSIZE+1  registered occupancy, 0..2**ADDRSIZE.
REQ-014 Port rerr  output  1  sticky underflow flag (present only with RPTR_UNDERFLOW_EN, see Configuration).

Function
REQ-015 Internal binary pointer rbin is ADDRSIZE+1 bits; rbnext = rbin + (rinc & ~rempty), modulo 2**(ADDRSIZE+1).
REQ-016 rgnext = (rbnext >> 1) ^ rbnext; rptr and rbin register rgnext and rbnext each cycle.
REQ-017 raddr = rbin[ADDRSIZE-1:0]; address advances one cycle after an honoured rinc.
REQ-018 rempty registers (rgnext == rq2_wptr); full Gray compare including MSB, no wrap ambiguity.
REQ-019 wbin = Gray-to-binary of rq2_wptr; rlevel registers (wbin - rbnext) modulo 2**(ADDRSIZE+1).
REQ-020 raempty registers (level_next <= ae_thr), where level_next is the value being written into rlevel; raempty=1 whenever rempty=1.
REQ-021 ae_thr loads ae_thresh on ae_load=1; the new threshold takes effect in the raempty update of the same edge's following cycle.
REQ-022 rinc while rempty=1: pointer, rptr, raddr unchanged; no other state disturbed.
REQ-023 Simultaneous honoured rinc and rq2_wptr change: both applied in same cycle; rempty/rlevel reflect both.
REQ-024 Pointer wrap past 2**(ADDRSIZE+1)-1 to 0 SHALL be seamless; rempty and rlevel correct across wrap.
REQ-025 rq2_wptr values implying occupancy > 2**ADDRSIZE are illegal; outputs then undefined, no lockup after reset.

Reset
REQ-026 On rrst=1 at rclk edge: rbin=0, rptr=0, rempty=1, raempty=1, rlevel=0, ae_thr=AE_RESET, rerr=0.
REQ-027 rrst has priority over rinc and ae_load; reset mid-operation discards pointer state immediately.

Configuration
REQ-028 Macro RPTR_UNDERFLOW_EN defined: rerr port exists; rerr sets to 1 the cycle after rinc=1 with rempty=1, holds until rrst.
REQ-029 Macro RPTR_UNDERFLOW_EN undefined: rerr port and its register absent; REQ-022 still holds.

Structure
REQ-030 Package fifo_ptr_pkg SHALL hold bin2gray/gray2bin functions and the default ADDRSIZE constant.
REQ-031 Sub-module gray2bin (parametrised width, combinational XOR prefix) SHALL convert rq2_wptr.

Verification (ADDRSIZE=4, AE_RESET=2)
REQ-032 Reset, rq2_wptr=0, rinc=1 for 5 cycles -> rptr=0, rempty=1, rlevel=0, rerr=1 (macro on).
REQ-033 rq2_wptr = Gray(16)=5'b11000, 16 reads back-to-back -> rlevel 16,15..0; rempty=1 after 16th; raempty=1 when rlevel<=2.
REQ-034 Start rbin=28, wptr=Gray(4), drain 8 entries -> raddr 12,13,14,15,0..3; rempty asserts with rbin=4 after wrap.
REQ-035 ae_load=1, ae_thresh=8 with rlevel=10, read 2 -> raempty rises on the cycle rlevel becomes 8.
REQ-036 Honoured rinc and wptr +1 in same cycle at rlevel=3 -> rlevel stays 3, rempty=0.
REQ-037 rrst asserted mid-drain at rlevel=7 -> next cycle rptr=0, rempty=1, rlevel=0, rerr=0.

Source files
------------

// File: rtl/fifo_ptr_pkg.sv
// -----------------------------------------------------------------------------
// fifo_ptr_pkg
// Shared helpers and constants for the FIFO pointer logic.
//   ADDRSIZE_DEFAULT : default FIFO address width (depth = 2**ADDRSIZE)
//   bin2gray()       : binary to reflected Gray code (up to 32 bits)
//   gray2bin()       : reflected Gray code to binary (up to 32 bits)
// Narrower values are zero-extended by the caller; zero extension does not
// change the result of either conversion.
// -----------------------------------------------------------------------------
package fifo_ptr_pkg;

    localparam int ADDRSIZE_DEFAULT = 4;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = 32'd0;
        for (int i = 0; i < 32; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// -----------------------------------------------------------------------------
// gray2bin
// Combinational Gray-to-binary converter: each binary bit is the XOR of the
// Gray bits at and above its position (XOR prefix from the MSB).
// Ports:
//   gray : input  [WIDTH-1:0]  Gray-coded value
//   bin  : output [WIDTH-1:0]  binary equivalent
// -----------------------------------------------------------------------------
module gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // XOR prefix: bit i = reduction XOR of gray[WIDTH-1:i]
    always_comb begin
        bin = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/rptr_empty_level.sv
// -----------------------------------------------------------------------------
// rptr_empty_level
// Read-side pointer of an asynchronous FIFO with empty flag, occupancy level
// and programmable almost-empty flag. All state is on rising rclk with a
// synchronous active-high reset (rrst).
// Optional feature: define RPTR_UNDERFLOW_EN to add the sticky underflow
// flag rerr (set the cycle after a read request while empty).
// Ports:
//   rclk      : read-domain clock
//   rrst      : synchronous active-high reset
//   rinc      : read request, honoured only while rempty=0
//   rq2_wptr  : [ADDRSIZE:0] Gray write pointer synchronised into rclk
//   ae_load   : load strobe for the almost-empty threshold
//   ae_thresh : [ADDRSIZE:0] threshold captured when ae_load=1
//   raddr     : [ADDRSIZE-1:0] binary RAM read address
//   rptr      : [ADDRSIZE:0] registered Gray read pointer
//   rempty    : registered FIFO-empty flag
//   raempty   : registered almost-empty flag (occupancy <= threshold)
//   rlevel    : [ADDRSIZE:0] registered occupancy 0..2**ADDRSIZE
//   rerr      : sticky underflow flag (RPTR_UNDERFLOW_EN only)
// -----------------------------------------------------------------------------
module rptr_empty_level
    import fifo_ptr_pkg::*;
#(
    parameter int ADDRSIZE = ADDRSIZE_DEFAULT,
    parameter int AE_RESET = 2
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic                ae_load,
    input  logic [ADDRSIZE:0]   ae_thresh,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rlevel
`ifdef RPTR_UNDERFLOW_EN
    ,
    output logic                rerr
`endif
);

    localparam int PW = ADDRSIZE + 1;

    logic [PW-1:0] rbin_r;
    logic [PW-1:0] ae_thr_r;
    logic [PW-1:0] wbin_s;
    logic [PW-1:0] rbnext_s;
    logic [PW-1:0] rgnext_s;
    logic [PW-1:0] level_next_s;
    logic          inc_s;
    logic          empty_next_s;
    logic          aempty_next_s;

    gray2bin #(
        .WIDTH (PW)
    ) u_wptr_g2b (
        .gray (rq2_wptr),
        .bin  (wbin_s)
    );

    // Next-state pointer, flag and level computation
    always_comb begin
        inc_s         = rinc & ~rempty;
        rbnext_s      = rbin_r + {{ADDRSIZE{1'b0}}, inc_s};
        rgnext_s      = (rbnext_s >> 1) ^ rbnext_s;
        // Full-width Gray compare: MSB distinguishes empty from full
        empty_next_s  = (rgnext_s == rq2_wptr);
        // Modulo subtraction keeps the level correct across pointer wrap
        level_next_s  = wbin_s - rbnext_s;
        // Threshold register (not ae_thresh) so a load affects the next update
        aempty_next_s = (level_next_s <= ae_thr_r) | empty_next_s;
    end

    // Pointer, flag and level registers
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin_r  <= {PW{1'b0}};
            rptr    <= {PW{1'b0}};
            rempty  <= 1'b1;
            raempty <= 1'b1;
            rlevel  <= {PW{1'b0}};
        end else begin
            rbin_r  <= rbnext_s;
            rptr    <= rgnext_s;
            rempty  <= empty_next_s;
            raempty <= aempty_next_s;
            rlevel  <= level_next_s;
        end
    end

    // Almost-empty threshold register
    always_ff @(posedge rclk) begin
        if (rrst) begin
            ae_thr_r <= PW'(AE_RESET);
        end else if (ae_load) begin
            ae_thr_r <= ae_thresh;
        end else begin
            ae_thr_r <= ae_thr_r;
        end
    end

`ifdef RPTR_UNDERFLOW_EN
    // Sticky underflow flag: read request while empty, cleared only by reset
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rerr <= 1'b0;
        end else if (rinc & rempty) begin
            rerr <= 1'b1;
        end else begin
            rerr <= rerr;
        end
    end
`endif

    assign raddr = rbin_r[ADDRSIZE-1:0];

endmodule

// File: tb/tb_rptr_empty_level.sv
// -----------------------------------------------------------------------------
// tb_rptr_empty_level
// Directed bench for rptr_empty_level (ADDRSIZE=4, AE_RESET=2).
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 time
// unit after the following rising edge. Expected values are hand-derived.
// -----------------------------------------------------------------------------
module tb_rptr_empty_level;

    logic       rclk = 1'b0;
    logic       rrst;
    logic       rinc;
    logic [4:0] rq2_wptr;
    logic       ae_load;
    logic [4:0] ae_thresh;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic       raempty;
    logic [4:0] rlevel;
`ifdef RPTR_UNDERFLOW_EN
    logic       rerr;
`endif

    int vectors     = 0;
    int miscompares = 0;

    rptr_empty_level #(
        .ADDRSIZE (4),
        .AE_RESET (2)
    ) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .rinc      (rinc),
        .rq2_wptr  (rq2_wptr),
        .ae_load   (ae_load),
        .ae_thresh (ae_thresh),
        .raddr     (raddr),
        .rptr      (rptr),
        .rempty    (rempty),
        .raempty   (raempty),
        .rlevel    (rlevel)
`ifdef RPTR_UNDERFLOW_EN
        ,
        .rerr      (rerr)
`endif
    );

    always #5 rclk = ~rclk;

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int exp_addr [8] = '{12, 13, 14, 15, 0, 1, 2, 3};

    initial begin
        rrst      = 1'b1;
        rinc      = 1'b0;
        rq2_wptr  = 5'b00000;
        ae_load   = 1'b0;
        ae_thresh = 5'd0;
        tick();
        tick();
        // Reset state
        check("rst_rptr", 32'(rptr), 32'd0);
        check("rst_raddr", 32'(raddr), 32'd0);
        check("rst_rempty", 32'(rempty), 32'd1);
        check("rst_raempty", 32'(raempty), 32'd1);
        check("rst_rlevel", 32'(rlevel), 32'd0);
`ifdef RPTR_UNDERFLOW_EN
        check("rst_rerr", 32'(rerr), 32'd0);
`endif

        // Reads while empty leave the pointer untouched
        rrst = 1'b0;
        rinc = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("uf_rptr", 32'(rptr), 32'd0);
            check("uf_raddr", 32'(raddr), 32'd0);
            check("uf_rempty", 32'(rempty), 32'd1);
            check("uf_rlevel", 32'(rlevel), 32'd0);
        end
`ifdef RPTR_UNDERFLOW_EN
        check("uf_rerr", 32'(rerr), 32'd1);
`endif
        rinc = 1'b0;

        // Full FIFO (Gray(16)) then 16 back-to-back reads
        rq2_wptr = 5'b11000;
        tick();
        check("full_rlevel", 32'(rlevel), 32'd16);
        check("full_rempty", 32'(rempty), 32'd0);
        check("full_raempty", 32'(raempty), 32'd0);
        rinc = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("drain_rlevel", 32'(rlevel), 32'(16 - k));
            check("drain_raddr", 32'(raddr), 32'(k % 16));
            check("drain_rempty", 32'(rempty), (k == 16) ? 32'd1 : 32'd0);
            check("drain_raempty", 32'(raempty), ((16 - k) <= 2) ? 32'd1 : 32'd0);
        end
        check("drain_rptr", 32'(rptr), 32'b11000);
        rinc = 1'b0;

        // Advance the read pointer to 28: write pointer Gray(28), drain 12
        rq2_wptr = 5'b10010;
        tick();
        check("w28_rlevel", 32'(rlevel), 32'd12);
        rinc = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
        end
        rinc = 1'b0;
        check("at28_raddr", 32'(raddr), 32'd12);
        check("at28_rempty", 32'(rempty), 32'd1);

        // Wrap: write pointer Gray(4), eight entries across the wrap
        rq2_wptr = 5'b00110;
        tick();
        check("wrap_rlevel", 32'(rlevel), 32'd8);
        check("wrap_rempty", 32'(rempty), 32'd0);
        rinc = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("wrap_raddr", 32'(raddr), 32'(exp_addr[k]));
            tick();
        end
        rinc = 1'b0;
        check("wrap_end_rempty", 32'(rempty), 32'd1);
        check("wrap_end_rptr", 32'(rptr), 32'b00110);
        check("wrap_end_raddr", 32'(raddr), 32'd4);
        check("wrap_end_rlevel", 32'(rlevel), 32'd0);

        // Threshold load to 8 with level 10 (write pointer Gray(14))
        rq2_wptr  = 5'b01001;
        ae_load   = 1'b1;
        ae_thresh = 5'd8;
        tick();
        ae_load = 1'b0;
        check("ae_rlevel10", 32'(rlevel), 32'd10);
        check("ae_raempty10", 32'(raempty), 32'd0);
        rinc = 1'b1;
        tick();
        check("ae_rlevel9", 32'(rlevel), 32'd9);
        check("ae_raempty9", 32'(raempty), 32'd0);
        tick();
        check("ae_rlevel8", 32'(rlevel), 32'd8);
        check("ae_raempty8", 32'(raempty), 32'd1);

        // Down to level 3 (read pointer 11)
        for (int k = 0; k < 5; k++) begin
            tick();
        end
        rinc = 1'b0;
        check("lvl3_rlevel", 32'(rlevel), 32'd3);

        // Simultaneous read and write (write pointer Gray(15))
        rinc     = 1'b1;
        rq2_wptr = 5'b01000;
        tick();
        rinc = 1'b0;
        check("sim_rlevel", 32'(rlevel), 32'd3);
        check("sim_rempty", 32'(rempty), 32'd0);
        check("sim_raddr", 32'(raddr), 32'd12);

        // Level 7 (write pointer Gray(19)), then reset mid-drain
        rq2_wptr = 5'b11010;
        tick();
        check("pre_rst_rlevel", 32'(rlevel), 32'd7);
        rinc = 1'b1;
        rrst = 1'b1;
        tick();
        check("mrst_rptr", 32'(rptr), 32'd0);
        check("mrst_rempty", 32'(rempty), 32'd1);
        check("mrst_raempty", 32'(raempty), 32'd1);
        check("mrst_rlevel", 32'(rlevel), 32'd0);
`ifdef RPTR_UNDERFLOW_EN
        check("mrst_rerr", 32'(rerr), 32'd0);
`endif

        // Threshold back to its reset value of 2
        rrst     = 1'b0;
        rinc     = 1'b0;
        rq2_wptr = 5'b00010;
        tick();
        check("thr_rst_rlevel3", 32'(rlevel), 32'd3);
        check("thr_rst_raempty3", 32'(raempty), 32'd0);
        rq2_wptr = 5'b00011;
        tick();
        check("thr_rst_rlevel2", 32'(rlevel), 32'd2);
        check("thr_rst_raempty2", 32'(raempty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
